alu_seq: RTL

Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the existing add/sub/and/or/slt opcodes and adds signed/unsigned compare, iterative unsigned multiply (hi:lo), and iterative unsigned divide (quotient/remainder). It sits between the register-read stage and the HI/LO/writeback logic of the multi-cycle core, and applies valid/ready backpressure while a long operation is in flight.

---
 rtl/alu_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU.
//   Single-cycle ops (ADD/SUB/AND/OR/SLT/SLTU), DIVU by zero and illegal
//   opcodes complete one cycle after acceptance. MULTU (shift-add) and DIVU
//   (restoring) iterate WIDTH cycles in BUSY. Results are held in DONE until
//   the consumer takes them.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready high only in IDLE)
//   a, b, op              operands and opcode, sampled on acceptance
//   out_valid/out_ready   result handshake (out_valid high only in DONE)
//   lo, hi                result / product lo:hi / quotient:remainder
//   zero, div_by_zero, illegal_op  result flags, meaningful with out_valid
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] wh, wl;     // working hi/lo: partial product or remainder/quotient
  logic             is_mul;
  logic [CNT_W-1:0] cnt;

  // Single-cycle result, computed straight from the inputs at acceptance.
  logic [WIDTH-1:0] r_lo, r_hi;
  logic             r_dbz, r_ill, r_long;

  always_comb begin
    r_lo   = '0;
    r_hi   = '0;
    r_dbz  = 1'b0;
    r_ill  = 1'b0;
    r_long = 1'b0;
    case (op)
      OP_ADD:   r_lo = a + b;
      OP_SUB:   r_lo = a + ~b + 1'b1;
      OP_AND:   r_lo = a & b;
      OP_OR:    r_lo = a | b;
      OP_SLT:   r_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  r_lo = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MULTU: r_long = 1'b1;
      OP_DIVU: begin
        if (b == '0) begin
          r_lo  = '1;
          r_hi  = a;
          r_dbz = 1'b1;
        end else begin
          r_long = 1'b1;
        end
      end
      default:  r_ill = 1'b1;
    endcase
  end

  // One multiply or divide step.
  logic [WIDTH:0]   m_sum, d_sh, d_diff;
  logic             d_ge;
  logic [WIDTH-1:0] wh_n, wl_n;

  always_comb begin
    m_sum  = {1'b0, wh} + (wl[0] ? {1'b0, a_r} : '0);
    d_sh   = {wh, wl[WIDTH-1]};
    d_diff = d_sh - {1'b0, b_r};
    // Remainder stays below b, so a borrow shows up as the top bit.
    d_ge   = ~d_diff[WIDTH];
    if (is_mul) begin
      wh_n = m_sum[WIDTH:1];
      wl_n = {m_sum[0], wl[WIDTH-1:1]};
    end else begin
      wh_n = d_ge ? d_diff[WIDTH-1:0] : d_sh[WIDTH-1:0];
      wl_n = {wl[WIDTH-2:0], d_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      wh          <= '0;
      wl          <= '0;
      is_mul      <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            a_r      <= a;
            b_r      <= b;
            is_mul   <= (op == OP_MULTU);
            if (r_long) begin
              state <= S_BUSY;
              cnt   <= CNT_W'(WIDTH);
              wh    <= '0;
              wl    <= (op == OP_MULTU) ? b : a;
            end else begin
              state       <= S_DONE;
              out_valid   <= 1'b1;
              lo          <= r_lo;
              hi          <= r_hi;
              zero        <= (r_lo == '0);
              div_by_zero <= r_dbz;
              illegal_op  <= r_ill;
            end
          end
        end
        S_BUSY: begin
          wh  <= wh_n;
          wl  <= wl_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            lo        <= wl_n;
            hi        <= wh_n;
            zero      <= is_mul ? ({wh_n, wl_n} == '0) : (wl_n == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            lo          <= '0;
            hi          <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
